// File: rtl/kb_pkg.sv
// Shared types and constants for the PS/2 keyboard input queue: decoder states,
// prefix bytes, bytes that are always ignored, and the queued entry layout.
package kb_pkg;

   typedef enum logic [1:0] {
      KB_IDLE    = 2'd0,
      KB_EXT     = 2'd1,
      KB_BRK     = 2'd2,
      KB_EXT_BRK = 2'd3
   } kb_state_e;

   localparam logic [7:0] KB_CODE_E0 = 8'hE0;
   localparam logic [7:0] KB_CODE_F0 = 8'hF0;

   // Bytes that never carry a key event (BAT, ACK, resend, echo, errors, pause lead-in)
   localparam int unsigned KB_NUM_DISCARD = 7;
   localparam logic [7:0] KB_DISCARD_CODES [KB_NUM_DISCARD] =
      '{8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFE, 8'hFF};

   typedef struct packed {
      logic       brk;
      logic       ext;
      logic [7:0] code;
   } kb_entry_t;

   localparam int unsigned KB_ENTRY_W = $bits(kb_entry_t);

   function automatic logic kb_is_discard(input logic [7:0] code);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < int'(KB_NUM_DISCARD); i++) begin
         if (code == KB_DISCARD_CODES[i]) hit = 1'b1;
      end
      return hit;
   endfunction

endpackage

// File: rtl/kb_input_queue_if.sv
// Push/pop bus between the keyboard decoder (master) and its event FIFO (slave).
interface kb_input_queue_if #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned W     = 10
);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic          push;
   logic [W-1:0]  wdata;
   logic          pop;
   logic [W-1:0]  rdata;
   logic          valid;
   logic          full;
   logic [CW-1:0] count;

   modport master (output push, wdata, pop, input rdata, valid, full, count);
   modport slave  (input push, wdata, pop, output rdata, valid, full, count);

endinterface

// File: rtl/kb_fifo.sv
// First-word-fall-through FIFO; a push into a full FIFO only lands when a pop
// happens on the same edge, otherwise it is refused.
module kb_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned W     = 10
) (
   input logic           clk,
   input logic           rst_n,
   kb_input_queue_if.slave bus
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          valid_q, valid_d;
   logic          full_q, full_d;
   logic          do_push_c, do_pop_c;

   always_comb begin
      do_pop_c  = bus.pop & valid_q;
      do_push_c = bus.push & (~full_q | do_pop_c);
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      if (do_push_c) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop_c)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push_c, do_pop_c})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      valid_d = (count_d != '0);
      full_d  = (count_d == CW'(DEPTH));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         valid_q  <= 1'b0;
         full_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         valid_q  <= valid_d;
         full_q   <= full_d;
      end
   end

   // Storage needs no reset: contents are only visible while valid
   always_ff @(posedge clk) begin
      if (do_push_c) mem_q[wr_ptr_q] <= bus.wdata;
   end

   assign bus.rdata = mem_q[rd_ptr_q];
   assign bus.valid = valid_q;
   assign bus.full  = full_q;
   assign bus.count = count_q;

endmodule

// File: rtl/kb_input_queue.sv
// PS/2 scancode input queue: strobe synchronizer, E0/F0 prefix decoder and event FIFO.
// Define KB_BREAK_EVENTS_EN to queue key-release entries; otherwise only makes are queued.
module kb_input_queue
   import kb_pkg::*;
#(
   parameter int unsigned DEPTH       = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                   Clk,
   input  logic                   Rst_n,
   input  logic [7:0]             Kb_Byte,
   input  logic                   Kb_Strobe,
   input  logic                   Key_Rd,
   input  logic                   Ovf_Clr,
   output logic [7:0]             Key_Code,
   output logic                   Key_Ext,
   output logic                   Key_Break,
   output logic                   Key_Valid,
   output logic [$clog2(DEPTH):0] Key_Count,
   output logic                   Overflow
);

`ifdef KB_BREAK_EVENTS_EN
   localparam logic BREAK_EN = 1'b1;
`else
   localparam logic BREAK_EN = 1'b0;
`endif

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;
   logic                   event_c;
   kb_state_e              state_q, state_d;
   logic                   push_c;
   kb_entry_t              entry_c;
   kb_entry_t              head_c;
   logic                   drop_c;
   logic                   overflow_q;
   logic                   is_prefix_c;

   kb_input_queue_if #(.DEPTH(DEPTH), .W(KB_ENTRY_W)) fif ();

   // Flops reset high so a strobe already high at reset release is not an edge
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         sync_q <= '1;
         hist_q <= 1'b1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], Kb_Strobe};
         hist_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign event_c     = sync_q[SYNC_STAGES-1] & ~hist_q;
   assign is_prefix_c = (Kb_Byte == KB_CODE_E0) || (Kb_Byte == KB_CODE_F0);

   always_comb begin
      state_d       = state_q;
      push_c        = 1'b0;
      entry_c       = '0;
      entry_c.code  = Kb_Byte;
      if (event_c && !kb_is_discard(Kb_Byte)) begin
         case (state_q)
            KB_IDLE: begin
               if (Kb_Byte == KB_CODE_E0)      state_d = KB_EXT;
               else if (Kb_Byte == KB_CODE_F0) state_d = KB_BRK;
               else                            push_c  = 1'b1;
            end
            KB_EXT: begin
               if (Kb_Byte == KB_CODE_F0) begin
                  state_d = KB_EXT_BRK;
               end else begin
                  state_d     = KB_IDLE;
                  push_c      = (Kb_Byte != KB_CODE_E0);
                  entry_c.ext = 1'b1;
               end
            end
            KB_BRK, KB_EXT_BRK: begin
               // A prefix here is a broken sequence: resynchronise without a push
               state_d     = KB_IDLE;
               push_c      = BREAK_EN & ~is_prefix_c;
               entry_c.brk = 1'b1;
               entry_c.ext = (state_q == KB_EXT_BRK);
            end
            default: state_d = KB_IDLE;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (!Rst_n) state_q <= KB_IDLE;
      else        state_q <= state_d;
   end

   assign drop_c = push_c & fif.full & ~(Key_Rd & fif.valid);

   // A dropped event wins over a coincident clear
   always_ff @(posedge Clk) begin
      if (!Rst_n)       overflow_q <= 1'b0;
      else if (drop_c)  overflow_q <= 1'b1;
      else if (Ovf_Clr) overflow_q <= 1'b0;
   end

   assign fif.push  = push_c;
   assign fif.wdata = entry_c;
   assign fif.pop   = Key_Rd;

   kb_fifo #(.DEPTH(DEPTH), .W(KB_ENTRY_W)) u_fifo (
      .clk   (Clk),
      .rst_n (Rst_n),
      .bus   (fif.slave)
   );

   assign head_c    = kb_entry_t'(fif.rdata);
   assign Key_Code  = head_c.code;
   assign Key_Ext   = head_c.ext;
   assign Key_Break = head_c.brk & BREAK_EN;
   assign Key_Valid = fif.valid;
   assign Key_Count = fif.count;
   assign Overflow  = overflow_q;

endmodule
